// File: rtl/xbar_pkg.sv
// Shared crossbar package: queue count, index width, arbiter state encoding
// and a one-hot to binary helper used by the crossbar and the selectors.
package xbar_pkg;

  localparam int NUM_QUEUES_C = 16;
  localparam int IDX_W_C      = 4;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // OR-fold of bit positions; exact for a one-hot input, zero for all-zero.
  function automatic logic [IDX_W_C-1:0] onehot2idx(input logic [NUM_QUEUES_C-1:0] oh);
    logic [IDX_W_C-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_QUEUES_C; i++) begin
      if (oh[i]) idx = idx | IDX_W_C'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set request strictly above rr_ptr,
// wrapping. The request vector is doubled so the wrap becomes a plain
// lowest-set-bit search over bits above rr_ptr.
module rr_pick
  import xbar_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_C,
  parameter int IDX_W      = IDX_W_C
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [IDX_W-1:0]      rr_ptr,
  output logic [NUM_QUEUES-1:0] win_onehot,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  any
);

  localparam int DW = 2 * NUM_QUEUES;

  logic [DW-1:0] w_dbl;
  logic [DW-1:0] w_mask;
  logic [DW-1:0] w_masked;
  logic [DW-1:0] w_lowest;

  // Mask off positions up to rr_ptr, isolate the lowest survivor, fold back.
  always_comb begin
    w_dbl = {req, req};
    for (int j = 0; j < DW; j++) begin
      w_mask[j] = (32'(j) > 32'(rr_ptr));
    end
    w_masked   = w_dbl & w_mask;
    w_lowest   = w_masked & (~w_masked + DW'(1));
    win_onehot = w_lowest[NUM_QUEUES-1:0] | w_lowest[DW-1:NUM_QUEUES];
    win_idx    = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (win_onehot[i]) win_idx = IDX_W'(i);
    end
    any = |req;
  end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Per-output packet arbiter for the 16x16 crossbar. Holds a round-robin grant
// for a whole packet and re-arbitrates on eop with no bubble.
// Optional feature: define ARB_TIMEOUT_EN to force-release an owner that
// sends no beat for TIMEOUT_CYCLES consecutive granted cycles.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int NUM_QUEUES     = NUM_QUEUES_C,
  parameter int IDX_W          = IDX_W_C,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_QUEUES-1:0] req,
  input  logic                  beat_valid,
  input  logic                  beat_eop,
  output logic [NUM_QUEUES-1:0] grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  pkt_done,
  output logic [CNT_W-1:0]      pkt_count,
  output logic                  timeout_pulse
);

  arb_state_t            r_state, w_state_nxt;
  logic [NUM_QUEUES-1:0] r_grant, w_grant_nxt;
  logic                  r_grant_valid;
  logic [IDX_W-1:0]      r_grant_idx, w_idx_nxt;
  logic [IDX_W-1:0]      r_rr_ptr, w_ptr_nxt;
  logic                  r_pkt_done, w_done_nxt;
  logic [CNT_W-1:0]      r_pkt_count, w_cnt_nxt;
  logic                  r_timeout, w_to_nxt;

  logic [IDX_W-1:0]      w_pick_ptr;
  logic [NUM_QUEUES-1:0] w_win_onehot;
  logic [IDX_W-1:0]      w_win_idx;
  logic                  w_any;
  logic                  w_eop;
  logic                  w_timeout;
  logic                  w_load_grant;

  // In XFER the owner becomes the new pointer on release, so search past it.
  assign w_pick_ptr = (r_state == XFER) ? r_grant_idx : r_rr_ptr;
  assign w_eop      = (r_state == XFER) && beat_valid && beat_eop;

  rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req        (req),
    .rr_ptr     (w_pick_ptr),
    .win_onehot (w_win_onehot),
    .win_idx    (w_win_idx),
    .any        (w_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_idle_cnt;

  // An eop needs beat_valid, so it always beats a same-cycle timeout.
  assign w_timeout = (r_state == XFER) && !beat_valid &&
                     (r_idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive beat-less granted cycles; cleared by a grant or a beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle_cnt <= '0;
    end else if (w_load_grant) begin
      r_idle_cnt <= '0;
    end else if (r_state == XFER) begin
      r_idle_cnt <= beat_valid ? '0 : r_idle_cnt + TO_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and registered-output logic for the IDLE/XFER arbiter.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_idx_nxt    = r_grant_idx;
    w_ptr_nxt    = r_rr_ptr;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_pkt_count;
    w_to_nxt     = 1'b0;
    w_load_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt  = w_win_onehot;
          w_idx_nxt    = w_win_idx;
          w_state_nxt  = XFER;
          w_load_grant = 1'b1;
        end
      end
      XFER: begin
        if (w_eop || w_timeout) begin
          w_ptr_nxt = r_grant_idx;
          if (w_eop) begin
            w_done_nxt = 1'b1;
            w_cnt_nxt  = r_pkt_count + CNT_W'(1);
          end else begin
            w_to_nxt = 1'b1;
          end
          if (w_any) begin
            w_grant_nxt  = w_win_onehot;
            w_idx_nxt    = w_win_idx;
            w_load_grant = 1'b1;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Output and pointer registers; reset drops ownership immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_rr_ptr      <= IDX_W'(NUM_QUEUES - 1);
      r_pkt_done    <= 1'b0;
      r_pkt_count   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_grant       <= w_grant_nxt;
      r_grant_valid <= |w_grant_nxt;
      r_grant_idx   <= w_idx_nxt;
      r_rr_ptr      <= w_ptr_nxt;
      r_pkt_done    <= w_done_nxt;
      r_pkt_count   <= w_cnt_nxt;
      r_timeout     <= w_to_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_valid   = r_grant_valid;
  assign grant_idx     = r_grant_idx;
  assign pkt_done      = r_pkt_done;
  assign pkt_count     = r_pkt_count;
  assign timeout_pulse = r_timeout;

endmodule
